// File: rtl/core_pkg.sv
// Shared types and widths for the 9-bit-instruction, 8-bit-register core.
package core_pkg;

    localparam int PC_WIDTH    = 8;
    localparam int CNT_WIDTH   = 16;
    localparam int INSTR_WIDTH = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !(&cnt_q)) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer owning the PC and cycle counter.
//   state    | meaning
//   S_IDLE   | waiting for start after reset
//   S_FETCH  | ir_load strobe
//   S_DECODE | latch decoder controls; branch to HALT on dec_halt
//   S_EXEC   | latch branch result; pick MEM, WB or PC update
//   S_MEM    | hold mem_re/mem_we until mem_ack
//   S_WB     | reg_we strobe, PC update
//   S_HALT   | stopped; start restarts at pc=0
module core_sequencer
    import core_pkg::*;
#(
    parameter int pc_width  = PC_WIDTH,
    parameter int cnt_width = CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 dec_reg_write,
    input  logic                 dec_mem_read,
    input  logic                 dec_mem_write,
    input  logic                 dec_halt,
    input  logic                 branch_taken,
    input  logic [pc_width-1:0]  branch_target,
    input  logic                 mem_ack,
    output logic [pc_width-1:0]  pc,
    output logic                 ir_load,
    output logic                 reg_we,
    output logic                 mem_re,
    output logic                 mem_we,
    output logic                 busy,
    output logic                 halted,
    output logic [cnt_width-1:0] cycle_count
);

    seq_state_t          state_q, state_d;
    logic [pc_width-1:0] pc_q, pc_d;
    logic [pc_width-1:0] br_target_q, br_target_d;
    logic                br_taken_q, br_taken_d;
    logic                rw_q, rw_d;
    logic                mr_q, mr_d;
    logic                mw_q, mw_d;
    logic                restart;
    logic                take_w;
    logic [pc_width-1:0] tgt_w;
    logic [pc_width-1:0] pc_upd_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            br_target_q <= '0;
            br_taken_q  <= 1'b0;
            rw_q        <= 1'b0;
            mr_q        <= 1'b0;
            mw_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            br_target_q <= br_target_d;
            br_taken_q  <= br_taken_d;
            rw_q        <= rw_d;
            mr_q        <= mr_d;
            mw_q        <= mw_d;
        end
    end

    // In EXEC the branch inputs are used directly so a plain instruction updates PC without waiting.
    assign take_w   = (state_q == S_EXEC) ? branch_taken  : br_taken_q;
    assign tgt_w    = (state_q == S_EXEC) ? branch_target : br_target_q;
    assign pc_upd_w = take_w ? tgt_w : pc_q + pc_width'(1);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        br_target_d = br_target_q;
        br_taken_d  = br_taken_q;
        rw_d        = rw_q;
        mr_d        = mr_q;
        mw_d        = mw_q;
        restart     = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    restart    = 1'b1;
                    pc_d       = '0;
                    br_taken_d = 1'b0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                rw_d    = dec_reg_write;
                mr_d    = dec_mem_read;
                mw_d    = dec_mem_write;
                state_d = dec_halt ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                br_taken_d  = branch_taken;
                br_target_d = branch_target;
                if (mr_q || mw_q) begin
                    state_d = S_MEM;
                end else if (rw_q) begin
                    state_d = S_WB;
                end else begin
                    pc_d       = pc_upd_w;
                    br_taken_d = 1'b0;
                    state_d    = S_FETCH;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (mr_q) begin
                        state_d = S_WB;
                    end else begin
                        pc_d       = pc_upd_w;
                        br_taken_d = 1'b0;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_WB: begin
                pc_d       = pc_upd_w;
                br_taken_d = 1'b0;
                state_d    = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pc      = pc_q;
    assign ir_load = (state_q == S_FETCH);
    assign reg_we  = (state_q == S_WB);
    assign mem_re  = (state_q == S_MEM) && mr_q;
    assign mem_we  = (state_q == S_MEM) && mw_q && !mr_q;
    assign busy    = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC)
                  || (state_q == S_MEM)   || (state_q == S_WB);
    assign halted  = (state_q == S_HALT);

    sat_counter #(
        .WIDTH(cnt_width)
    ) u_cycle_cnt (
        .clk    (clk),
        .reset  (reset),
        .en_i   (busy),
        .clr_i  (restart),
        .count_o(cycle_count)
    );

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control sequencer for the 9-bit-instruction, 8-bit-register core. It steps each instruction through fetch, decode, execute, memory and writeback. It issues the instruction-register load, register-file write and data-memory strobes from the decoder's per-instruction control outputs, and owns the program counter and a cycle counter. The block sits between the instruction ROM/decoder and the register file/ALU/data memory, and is the only source of architectural state updates.

## Interface
- `pc_width`, 8: program counter width; the PC wraps modulo 2^pc_width.
- `cnt_width`, 16: width of the cycle counter.

- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: single-cycle pulse; honoured only in IDLE or HALT.
- `dec_reg_write` in 1: decoder register-write control.
- `dec_mem_read` in 1: decoder memory-read control.
- `dec_mem_write` in 1: decoder memory-write control.
- `dec_halt` in 1: decoder halt control.
- `branch_taken` in 1: ALU compare result, sampled in EXEC.
- `branch_target` in pc_width: jump/branch target, sampled in EXEC.
- `mem_ack` in 1: data memory access complete.
- `pc` out pc_width: current instruction address.
- `ir_load` out 1: instruction register capture strobe.
- `reg_we` out 1: register-file write enable, one-cycle pulse.
- `mem_re` out 1: data-memory read request, level.
- `mem_we` out 1: data-memory write request, level.
- `busy` out 1: high in FETCH, DECODE, EXEC, MEM and WB.
- `halted` out 1: high in HALT.
- `cycle_count` out cnt_width: busy cycles since the last start.

## Operation
- **States:** IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- **IDLE:**
  - On `start`: pc←0, cycle_count←0, go to FETCH.
  - Otherwise remain in IDLE.
- **FETCH:** `ir_load`=1; next state DECODE.
- **DECODE:**
  - Latch `dec_reg_write`, `dec_mem_read`, `dec_mem_write` into internal flags.
  - If `dec_halt`: go to HALT; pc is not advanced.
  - Otherwise go to EXEC.
- **EXEC:**
  - Latch `branch_taken` and `branch_target`.
  - If a memory flag is set: go to MEM.
  - Else if the write flag is set: go to WB.
  - Otherwise: PC update, then FETCH.
- **MEM:**
  - `mem_re` = read flag. `mem_we` = write flag AND NOT read flag; read has priority if both are set.
  - Requests are held until `mem_ack`.
  - On `mem_ack` with the read flag set: go to WB.
  - On `mem_ack` otherwise: PC update, then FETCH.
  - There is no timeout.
- **WB:** `reg_we`=1, PC update, then FETCH.
- **PC update:** pc←latched target if a taken branch was latched, else pc+1 (modulo 2^pc_width; 0xFF+1=0x00). The latched branch is cleared at the update.
- **HALT:** `halted`=1. On `start`: pc←0, cycle_count←0, go to FETCH.
- **start in any busy state:** ignored.
- **cycle_count:** increments every cycle `busy`=1; saturates at all-ones (no wrap); holds in IDLE and HALT.

## Timing
- **Reset values:** state IDLE; pc=0; cycle_count=0; ir_load, reg_we, mem_re, mem_we, busy, halted all 0; internal flags cleared.
- **Reset mid-operation:** any in-flight memory request is dropped immediately (asynchronous); no partial writeback.
- **Outputs:** all are Moore, decoded from registered state/flags; no combinational path from inputs to outputs.
- **Latency from FETCH entry to the next FETCH entry:**
  - Non-writing, non-memory instruction: 3 cycles.
  - ALU write: 4 cycles.
  - Store: 4+N cycles.
  - Load: 5+N cycles.
  - N = extra cycles waiting for `mem_ack`; N=0 when ack arrives in the first MEM cycle.
- **Strobe timing:**
  - `reg_we` is high exactly one cycle per writing instruction.
  - `ir_load` is high exactly one cycle per instruction.
- **Pipelining:** none; decoder inputs must be stable in DECODE, branch inputs in EXEC.
- **Simultaneous mem_ack and reset:** reset wins.
- **mem_ack outside MEM:** ignored.

## Structure
- Shared package `core_pkg` holds:
  - the state enum `seq_state_t`;
  - width constants PC_WIDTH=8 and CNT_WIDTH=16;
  - the instruction width constant (9).
- Sub-module `sat_counter` (parameterised width; enable, clear, saturating) implements `cycle_count`.
- The FSM, flag latches and PC remain in `core_sequencer`.

## Test plan
- **Reset/start:** assert reset mid-MEM with `mem_re`=1. Required: all outputs 0 and state IDLE immediately. Then `start` → FETCH next cycle with pc=0.
- **ALU write sequence:** `dec_reg_write`=1 only. Required: FETCH, DECODE, EXEC, WB; `reg_we` pulses once; pc 0→1; cycle_count=4 at the next FETCH.
- **Load with wait states:** `dec_mem_read`=1, `dec_reg_write`=1, `mem_ack` delayed 3 cycles. Required: `mem_re` high 4 cycles; WB follows; total 8 cycles.
- **Taken branch:** `branch_taken`=1, `branch_target`=0x3C, no writes. Required: pc=0x3C after 3 cycles, no `reg_we`, no mem strobes.
- **PC wrap and read priority:** pc=0xFF, instruction with both memory flags set. Required: only `mem_re` is asserted; pc becomes 0x00.
- **Halt and restart:** `dec_halt` at pc=5. Required: HALT, pc holds 5, cycle_count frozen. `start` in HALT restarts at pc=0. `start` pulsed while busy has no effect.
